rysy_mem_arb: RTL and testbench

// Parametrised N-channel arbiter between rysy requesters (instruction fetch, data port, debug/DMA) and one

---
 rtl/rysy_mem_arb.sv | 165 ++++++++++++++++
 tb/tb_rysy_mem_arb.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rysy_mem_arb.sv
// rysy_mem_arb: N-channel req/gnt arbiter in front of one single-port synchronous memory.
// Round-robin or fixed priority, a lock for atomic sequences, and in-order completions.
module rysy_mem_arb #(
    parameter int N_CH     = 2,
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int READ_LAT = 1,
    parameter int ARB_MODE = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_CH-1:0]        m_req,
    input  logic [N_CH-1:0]        m_we,
    input  logic [N_CH-1:0]        m_lock,
    input  logic [N_CH*AW-1:0]     m_addr,
    input  logic [N_CH*DW-1:0]     m_wdata,
    input  logic [N_CH*(DW/8)-1:0] m_be,
    output logic [N_CH-1:0]        m_gnt,
    output logic [N_CH-1:0]        m_rvalid,
    output logic [DW-1:0]          m_rdata,
    output logic [AW-1:0]          addr,
    output logic [DW-1:0]          wdata,
    output logic                   we,
    output logic [DW/8-1:0]        be,
    input  logic [DW-1:0]          rdata
);
    localparam int BW = DW / 8;
    localparam int CW = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic                        gnt_vld;
    logic [CW-1:0]               gnt_idx;
    logic                        lock_vld_q, lock_vld_d;
    logic [CW-1:0]               lock_own_q, lock_own_d;
    logic [READ_LAT-1:0]         pipe_vld_q, pipe_vld_d;
    logic [READ_LAT-1:0][CW-1:0] pipe_ch_q, pipe_ch_d;

    generate
        if (N_CH == 1) begin : g_single
            always_comb begin
                gnt_vld = m_req[0];
                gnt_idx = '0;
            end
        end else if (ARB_MODE == 0) begin : g_fixed
            always_comb begin
                gnt_vld = 1'b0;
                gnt_idx = '0;
                if (lock_vld_q) begin
                    gnt_vld = m_req[lock_own_q];
                    gnt_idx = lock_own_q;
                end else begin
                    // descending scan so the lowest requesting index is the last writer
                    for (int i = N_CH - 1; i >= 0; i--) begin
                        if (m_req[i]) begin
                            gnt_vld = 1'b1;
                            gnt_idx = CW'(i);
                        end
                    end
                end
            end
        end else begin : g_rr
            logic [CW-1:0] rr_ptr_q, rr_ptr_d;

            always_comb begin
                logic [CW-1:0] cand;
                int            c;
                cand    = '0;
                c       = 0;
                gnt_vld = 1'b0;
                gnt_idx = '0;
                if (lock_vld_q) begin
                    gnt_vld = m_req[lock_own_q];
                    gnt_idx = lock_own_q;
                end else begin
                    // descending offset scan: the candidate closest to rr_ptr wins
                    for (int i = N_CH - 1; i >= 0; i--) begin
                        c = int'(rr_ptr_q) + i;
                        if (c >= N_CH) begin
                            c = c - N_CH;
                        end
                        cand = CW'(c);
                        if (m_req[cand]) begin
                            gnt_vld = 1'b1;
                            gnt_idx = cand;
                        end
                    end
                end
            end

            // pointer stays frozen while a lock is held, including the owner's grants
            always_comb begin
                rr_ptr_d = rr_ptr_q;
                if (gnt_vld && !lock_vld_q) begin
                    rr_ptr_d = (gnt_idx == CW'(N_CH - 1)) ? '0 : gnt_idx + 1'b1;
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    rr_ptr_q <= '0;
                end else begin
                    rr_ptr_q <= rr_ptr_d;
                end
            end
        end
    endgenerate

    always_comb begin
        m_gnt      = '0;
        addr       = '0;
        wdata      = '0;
        we         = 1'b0;
        be         = '0;
        lock_vld_d = lock_vld_q;
        lock_own_d = lock_own_q;
        if (gnt_vld) begin
            m_gnt[gnt_idx] = 1'b1;
            if (m_lock[gnt_idx]) begin
                lock_vld_d = 1'b1;
                lock_own_d = gnt_idx;
            end else begin
                lock_vld_d = 1'b0;
            end
        end
        for (int k = 0; k < N_CH; k++) begin
            if (gnt_vld && gnt_idx == CW'(k)) begin
                addr  = m_addr[k*AW +: AW];
                wdata = m_wdata[k*DW +: DW];
                be    = m_be[k*BW +: BW];
                we    = m_we[k];
            end
        end
    end

    always_comb begin
        pipe_vld_d    = '0;
        pipe_ch_d     = '0;
        pipe_vld_d[0] = gnt_vld;
        pipe_ch_d[0]  = gnt_idx;
        for (int i = 1; i < READ_LAT; i++) begin
            pipe_vld_d[i] = pipe_vld_q[i-1];
            pipe_ch_d[i]  = pipe_ch_q[i-1];
        end
        m_rvalid = '0;
        if (pipe_vld_q[READ_LAT-1]) begin
            m_rvalid[pipe_ch_q[READ_LAT-1]] = 1'b1;
        end
    end

    assign m_rdata = rdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            lock_vld_q <= 1'b0;
            lock_own_q <= '0;
            pipe_vld_q <= '0;
            pipe_ch_q  <= '0;
        end else begin
            lock_vld_q <= lock_vld_d;
            lock_own_q <= lock_own_d;
            pipe_vld_q <= pipe_vld_d;
            pipe_ch_q  <= pipe_ch_d;
        end
    end

endmodule

// File: tb/tb_rysy_mem_arb.sv
// Scoreboard bench for rysy_mem_arb: a round-robin READ_LAT=1 instance and a fixed-priority
// READ_LAT=3 instance, each with its own memory model and a transaction-level reference model.
module tb_rysy_mem_arb;
    localparam int NC = 3;
    localparam int NI = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic [NC-1:0]     req     [NI];
    logic [NC-1:0]     we_i    [NI];
    logic [NC-1:0]     lock_i  [NI];
    logic [NC*32-1:0]  addr_i  [NI];
    logic [NC*32-1:0]  wdata_i [NI];
    logic [NC*4-1:0]   be_i    [NI];
    logic [NC-1:0]     gnt     [NI];
    logic [NC-1:0]     rvalid  [NI];
    logic [31:0]       m_rdata [NI];
    logic [31:0]       mem_addr[NI];
    logic [31:0]       mem_wdata[NI];
    logic              mem_we  [NI];
    logic [3:0]        mem_be  [NI];
    logic [31:0]       mem_rdata[NI];

    rysy_mem_arb #(.N_CH(NC), .AW(32), .DW(32), .READ_LAT(1), .ARB_MODE(1)) u_rr (
        .clk(clk), .rst(rst), .m_req(req[0]), .m_we(we_i[0]), .m_lock(lock_i[0]),
        .m_addr(addr_i[0]), .m_wdata(wdata_i[0]), .m_be(be_i[0]), .m_gnt(gnt[0]),
        .m_rvalid(rvalid[0]), .m_rdata(m_rdata[0]), .addr(mem_addr[0]), .wdata(mem_wdata[0]),
        .we(mem_we[0]), .be(mem_be[0]), .rdata(mem_rdata[0]));

    rysy_mem_arb #(.N_CH(NC), .AW(32), .DW(32), .READ_LAT(3), .ARB_MODE(0)) u_fp (
        .clk(clk), .rst(rst), .m_req(req[1]), .m_we(we_i[1]), .m_lock(lock_i[1]),
        .m_addr(addr_i[1]), .m_wdata(wdata_i[1]), .m_be(be_i[1]), .m_gnt(gnt[1]),
        .m_rvalid(rvalid[1]), .m_rdata(m_rdata[1]), .addr(mem_addr[1]), .wdata(mem_wdata[1]),
        .we(mem_we[1]), .be(mem_be[1]), .rdata(mem_rdata[1]));

    function automatic int lat_of(int i);
        return (i == 0) ? 1 : 3;
    endfunction

    // single-port synchronous memories answering each DUT
    for (genvar gi = 0; gi < NI; gi++) begin : g_mem
        logic [31:0] mem  [256];
        logic [31:0] rd_p [3];
        initial for (int w = 0; w < 256; w++) mem[w] = '0;
        always @(posedge clk) begin
            rd_p[0] <= mem[mem_addr[gi][9:2]];
            rd_p[1] <= rd_p[0];
            rd_p[2] <= rd_p[1];
            if (mem_we[gi]) begin
                for (int b = 0; b < 4; b++) begin
                    if (mem_be[gi][b]) mem[mem_addr[gi][9:2]][b*8 +: 8] <= mem_wdata[gi][b*8 +: 8];
                end
            end
        end
        assign mem_rdata[gi] = rd_p[lat_of(gi) - 1];
    end

    typedef struct {
        bit          bub;
        bit          we;
        bit          lk;
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  be;
    } op_t;

    typedef struct {
        int          ch;
        bit          we;
        logic [31:0] d;
        int          due;
    } exp_t;

    op_t         opq [NI*NC][$];
    exp_t        sbq [NI][$];
    logic [31:0] ref_mem [NI][256];
    int          rr_m  [NI];
    int          own_m [NI];
    bit          lkv_m [NI];
    bit          granted [NI][NC];
    int          cyc = 0;
    int          n_chk = 0;
    int          n_pass = 0;
    exp_t        mon_e;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    endtask

    // completion monitor: pops the scoreboard whenever a DUT presents rvalid
    always @(negedge clk) begin
        for (int i = 0; i < NI; i++) begin
            if (rvalid[i] != '0) begin
                if (sbq[i].size() == 0) begin
                    check($sformatf("rvalid_unexpected_i%0d", i), 64'(rvalid[i]), 64'd0);
                end else begin
                    mon_e = sbq[i].pop_front();
                    check($sformatf("rvalid_ch_i%0d", i), 64'(rvalid[i]), 64'(1 << mon_e.ch));
                    check($sformatf("rvalid_cycle_i%0d", i), 64'(cyc), 64'(mon_e.due));
                    if (!mon_e.we) check($sformatf("rdata_i%0d", i), 64'(m_rdata[i]), 64'(mon_e.d));
                end
            end else if (sbq[i].size() > 0 && sbq[i][0].due <= cyc) begin
                mon_e = sbq[i].pop_front();
                check($sformatf("rvalid_missing_i%0d", i), 64'(rvalid[i]), 64'(1 << mon_e.ch));
            end
        end
    end

    task automatic drive();
        for (int i = 0; i < NI; i++) begin
            for (int k = 0; k < NC; k++) begin
                int s = i * NC + k;
                if (opq[s].size() > 0 && !opq[s][0].bub) begin
                    req[i][k]             = 1'b1;
                    we_i[i][k]            = opq[s][0].we;
                    lock_i[i][k]          = opq[s][0].lk;
                    addr_i[i][k*32 +: 32] = opq[s][0].a;
                    wdata_i[i][k*32 +: 32]= opq[s][0].d;
                    be_i[i][k*4 +: 4]     = opq[s][0].be;
                end else begin
                    req[i][k]             = 1'b0;
                    we_i[i][k]            = 1'b0;
                    lock_i[i][k]          = 1'b0;
                    addr_i[i][k*32 +: 32] = '0;
                    wdata_i[i][k*32 +: 32]= '0;
                    be_i[i][k*4 +: 4]     = '0;
                end
            end
        end
    endtask

    // reference model: decide the winner from the rules, check the bus, record the completion
    task automatic model_step();
        for (int i = 0; i < NI; i++) begin
            int          w = -1;
            logic [31:0] e_a = '0, e_d = '0;
            logic [3:0]  e_be = '0;
            logic        e_we = 1'b0;
            if (lkv_m[i]) begin
                if (req[i][own_m[i]]) w = own_m[i];
            end else if (i == 1) begin
                for (int k = 0; k < NC; k++) if (w < 0 && req[i][k]) w = k;
            end else begin
                for (int k = 0; k < NC; k++) begin
                    int c = (rr_m[i] + k) % NC;
                    if (w < 0 && req[i][c]) w = c;
                end
            end
            if (w >= 0) begin
                op_t f = opq[i*NC + w][0];
                e_a = f.a; e_d = f.d; e_be = f.be; e_we = f.we;
            end
            check($sformatf("gnt_i%0d", i), 64'(gnt[i]), (w < 0) ? 64'd0 : 64'(1 << w));
            check($sformatf("addr_i%0d", i), 64'(mem_addr[i]), 64'(e_a));
            check($sformatf("wdata_i%0d", i), 64'(mem_wdata[i]), 64'(e_d));
            check($sformatf("be_i%0d", i), 64'(mem_be[i]), 64'(e_be));
            check($sformatf("we_i%0d", i), 64'(mem_we[i]), 64'(e_we));
            for (int k = 0; k < NC; k++) granted[i][k] = (k == w);
            if (w >= 0) begin
                op_t  f   = opq[i*NC + w][0];
                int   idx = int'(f.a[9:2]);
                exp_t e;
                e.ch = w; e.we = f.we; e.d = ref_mem[i][idx]; e.due = cyc + lat_of(i);
                sbq[i].push_back(e);
                if (f.we) begin
                    for (int b = 0; b < 4; b++) if (f.be[b]) ref_mem[i][idx][b*8 +: 8] = f.d[b*8 +: 8];
                end
                if (!lkv_m[i]) rr_m[i] = (w + 1) % NC;
                if (f.lk) begin
                    lkv_m[i] = 1'b1;
                    own_m[i] = w;
                end else begin
                    lkv_m[i] = 1'b0;
                end
            end
        end
    endtask

    task automatic pop_done();
        for (int i = 0; i < NI; i++) begin
            for (int k = 0; k < NC; k++) begin
                int s = i * NC + k;
                if (opq[s].size() > 0 && (opq[s][0].bub || granted[i][k])) void'(opq[s].pop_front());
                granted[i][k] = 1'b0;
            end
        end
    endtask

    task automatic cycle_once();
        drive();
        @(negedge clk);
        model_step();
        @(posedge clk);
        pop_done();
        #1;
    endtask

    function automatic bit busy();
        for (int s = 0; s < NI*NC; s++) if (opq[s].size() > 0) return 1'b1;
        for (int i = 0; i < NI; i++) if (sbq[i].size() > 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic run_idle(int budget);
        int n = 0;
        while (busy() && n < budget) begin
            cycle_once();
            n++;
        end
        check("drain_within_budget", 64'(busy()), 64'd0);
        for (int s = 0; s < NI*NC; s++) opq[s].delete();
        cycle_once();
    endtask

    task automatic push_op(int ch, bit we, bit lk, logic [31:0] a, logic [31:0] d, logic [3:0] be);
        op_t o;
        o.bub = 1'b0; o.we = we; o.lk = lk; o.a = a; o.d = d; o.be = be;
        for (int i = 0; i < NI; i++) opq[i*NC + ch].push_back(o);
    endtask

    task automatic push_bub(int ch);
        op_t o;
        o.bub = 1'b1; o.we = 1'b0; o.lk = 1'b0; o.a = '0; o.d = '0; o.be = '0;
        for (int i = 0; i < NI; i++) opq[i*NC + ch].push_back(o);
    endtask

    // reset taken at the end of this cycle: completions due later than now are lost
    task automatic do_reset();
        for (int s = 0; s < NI*NC; s++) opq[s].delete();
        for (int i = 0; i < NI; i++) begin
            while (sbq[i].size() > 0 && sbq[i][$].due > cyc) void'(sbq[i].pop_back());
            rr_m[i] = 0; lkv_m[i] = 1'b0; own_m[i] = 0;
        end
        rst = 1'b1;
        cycle_once();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        for (int i = 0; i < NI; i++) begin
            req[i] = '0; we_i[i] = '0; lock_i[i] = '0;
            addr_i[i] = '0; wdata_i[i] = '0; be_i[i] = '0;
            rr_m[i] = 0; own_m[i] = 0; lkv_m[i] = 1'b0;
            for (int w = 0; w < 256; w++) ref_mem[i][w] = '0;
        end
        @(posedge clk);
        #1;
        cycle_once();
        cycle_once();
        rst = 1'b0;
        cycle_once();

        // two channels contending with held reads
        for (int n = 0; n < 4; n++) begin
            push_op(0, 1'b0, 1'b0, 32'h10, 32'h0, 4'hF);
            push_op(1, 1'b0, 1'b0, 32'h20, 32'h0, 4'hF);
        end
        run_idle(100);

        // all three channels requesting together
        for (int n = 0; n < 3; n++)
            for (int k = 0; k < NC; k++) push_op(k, 1'b0, 1'b0, 32'(k*4 + n*16), 32'h0, 4'hF);
        run_idle(100);

        // locked read-modify-write by ch1 while ch0 keeps asking for the same word
        push_bub(0);
        for (int n = 0; n < 6; n++) push_op(0, 1'b0, 1'b0, 32'h40, 32'h0, 4'hF);
        push_op(1, 1'b1, 1'b1, 32'h30, 32'h11, 4'hF);
        push_op(1, 1'b0, 1'b1, 32'h40, 32'h0, 4'hF);
        push_op(1, 1'b1, 1'b0, 32'h40, 32'hCAFE0001, 4'hF);
        run_idle(100);

        // back-to-back reads from one channel
        push_op(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'hF);
        push_op(0, 1'b0, 1'b0, 32'h4, 32'h0, 4'hF);
        push_op(0, 1'b0, 1'b0, 32'h8, 32'h0, 4'hF);
        run_idle(100);

        // partial byte write, then read it back
        push_op(0, 1'b1, 1'b0, 32'h8, 32'hAABBCCDD, 4'b0010);
        push_op(0, 1'b0, 1'b0, 32'h8, 32'h0, 4'hF);
        run_idle(100);
        check("mem_0x8_rr", 64'(g_mem[0].mem[2]), 64'h0000CC00);
        check("mem_0x8_fp", 64'(g_mem[1].mem[2]), 64'h0000CC00);

        // reset with reads in flight and a lock held
        push_bub(0);
        for (int n = 0; n < 10; n++) begin
            push_op(0, 1'b0, 1'b0, 32'h40, 32'h0, 4'hF);
            push_op(1, 1'b0, 1'b1, 32'(16 + n*4), 32'h0, 4'hF);
        end
        for (int n = 0; n < 4; n++) cycle_once();
        do_reset();
        for (int n = 0; n < 2; n++)
            for (int k = 0; k < NC; k++) push_op(k, 1'b0, 1'b0, 32'(k*4), 32'h0, 4'hF);
        run_idle(100);

        // random traffic, locks included; each channel's last op releases any lock it holds
        for (int s = 0; s < NI*NC; s++) begin
            for (int n = 0; n < 30; n++) begin
                op_t o;
                o.bub = (n < 29) && ($urandom_range(0, 3) == 0);
                o.we  = 1'($urandom_range(0, 1));
                o.lk  = (n < 29) && ($urandom_range(0, 7) == 0);
                o.a   = 32'($urandom_range(0, 15)) << 2;
                o.d   = $urandom;
                o.be  = 4'($urandom_range(0, 15));
                opq[s].push_back(o);
            end
        end
        run_idle(3000);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
